rv_mc_controller: RTL and testbench

- Multi-cycle control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback over the shared PC, instruction memory, decoder, register file and ALU.
- Drives the PC-update, IR-load, register-write, operand-select and data-memory handshake signals from the decoder fields.
- One instruction is in flight at a time.

---
 rtl/rv_mc_controller_if.sv | 43 ++++
 rtl/rv_mc_controller.sv | 246 ++++++++++++++++++++++++
 tb/tb_rv_mc_controller.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rv_mc_controller_if.sv
// Control bundle between the multi-cycle controller and the RV32I datapath.
// The controller takes the master side; the datapath/decoder/memory side is
// the slave. Decoder fields and handshake inputs flow master-ward, all
// control strobes flow slave-ward.
interface rv_mc_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             br_cond;
  logic             dmem_ready;
  logic             ir_we;
  logic             pc_we;
  logic             branch_taken;
  logic             jump;
  logic             regWrite;
  logic             alu_src_a;
  logic             alu_src_b;
  logic [2:0]       imm_sel;
  logic [3:0]       alu_ctrl;
  logic [1:0]       wb_sel;
  logic             dmem_req;
  logic             dmem_we;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  opcode, funct3, funct7, br_cond, dmem_ready,
    output ir_we, pc_we, branch_taken, jump, regWrite, alu_src_a, alu_src_b,
           imm_sel, alu_ctrl, wb_sel, dmem_req, dmem_we, halted, illegal,
           cycle_cnt, instret_cnt
  );

  modport slave (
    output opcode, funct3, funct7, br_cond, dmem_ready,
    input  ir_we, pc_we, branch_taken, jump, regWrite, alu_src_a, alu_src_b,
           imm_sel, alu_ctrl, wb_sel, dmem_req, dmem_we, halted, illegal,
           cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/rv_mc_controller.sv
// Multi-cycle RV32I control FSM: one instruction in flight, sequenced
// through fetch/decode/execute/memory/writeback.
// Optional performance counters are built when RV_MC_PERF_CNT_EN is defined;
// otherwise cycle_cnt/instret_cnt are tied to zero.
//
// state   | meaning
// FETCH   | load IR from combinational instruction memory
// DECODE  | classify opcode, latch class and ALU fields
// EXECUTE | ALU operands/op stable; branches resolve and retire here
// MEM     | data-memory request held until ready (optional timeout)
// WB      | register write and PC update
// HALT    | SYSTEM reached, sticky until reset
// TRAP    | illegal opcode or memory timeout, sticky until reset
module rv_mc_controller #(
  parameter int unsigned MAX_WAIT = 0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  rv_mc_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_RALU, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  // Wait timer is a down-counter loaded on the way into MEM; reaching zero
  // without ready on the last allowed MEM cycle means timeout.
  localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  state_t            state_q, state_d;
  cls_t              cls_q, dec_cls;
  logic [2:0]        f3_q;
  logic              f7b5_q;
  logic [WAIT_W-1:0] wait_q;
  logic              dec_ok, dec_sys;
  logic [3:0]        alu_op;
  logic [2:0]        imm_op;
  logic              unused_f7;

  // Only funct7[5] matters to this controller.
  assign unused_f7 = ^{bus.funct7[6], bus.funct7[4:0]};

  // Opcode classification used while in DECODE
  always_comb begin
    dec_cls = C_RALU;
    dec_ok  = 1'b1;
    dec_sys = 1'b0;
    case (bus.opcode)
      7'b0110011: dec_cls = C_RALU;
      7'b0010011: dec_cls = C_IALU;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b0110111: dec_cls = C_LUI;
      7'b0010111: dec_cls = C_AUIPC;
      7'b1110011: dec_sys = 1'b1;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Instruction class and ALU fields, captured once per instruction in DECODE
  always_ff @(posedge clk) begin
    if (reset) begin
      cls_q  <= C_RALU;
      f3_q   <= 3'b000;
      f7b5_q <= 1'b0;
    end else if (state_q == S_DECODE) begin
      cls_q  <= dec_cls;
      f3_q   <= bus.funct3;
      f7b5_q <= bus.funct7[5];
    end
  end

  // Memory wait timer: load in EXECUTE, count down while MEM waits
  always_ff @(posedge clk) begin
    if (reset)
      wait_q <= '0;
    else if (state_q == S_EXECUTE)
      wait_q <= WAIT_LD;
    else if (state_q == S_MEM && !bus.dmem_ready && wait_q != '0)
      wait_q <= wait_q - WAIT_W'(1);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (dec_sys)     state_d = S_HALT;
        else if (!dec_ok) state_d = S_TRAP;
        else             state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (cls_q == C_BRANCH)                         state_d = S_FETCH;
        else if (cls_q == C_LOAD || cls_q == C_STORE) state_d = S_MEM;
        else                                           state_d = S_WB;
      end
      S_MEM: begin
        if (bus.dmem_ready)
          state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
        else if (MAX_WAIT != 0 && wait_q == '0)
          state_d = S_TRAP;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = state_q;
    endcase
  end

  // ALU operation from latched class and function fields
  always_comb begin
    alu_op = ALU_ADD;
    case (cls_q)
      C_RALU, C_IALU: begin
        case (f3_q)
          3'b000:  alu_op = (cls_q == C_RALU && f7b5_q) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = f7b5_q ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      C_BRANCH: alu_op = ALU_SUB;
      C_LUI:    alu_op = ALU_PASS;
      default:  alu_op = ALU_ADD;
    endcase
  end

  // Immediate format by class
  always_comb begin
    imm_op = 3'd0;
    case (cls_q)
      C_STORE:        imm_op = 3'd1;
      C_BRANCH:       imm_op = 3'd2;
      C_LUI, C_AUIPC: imm_op = 3'd3;
      C_JAL:          imm_op = 3'd4;
      default:        imm_op = 3'd0;
    endcase
  end

  // Control outputs decoded from state; forced low while reset is asserted
  always_comb begin
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jump         = 1'b0;
    bus.regWrite     = 1'b0;
    bus.alu_src_a    = 1'b0;
    bus.alu_src_b    = 1'b0;
    bus.imm_sel      = 3'd0;
    bus.alu_ctrl     = 4'd0;
    bus.wb_sel       = 2'd0;
    bus.dmem_req     = 1'b0;
    bus.dmem_we      = 1'b0;
    bus.halted       = 1'b0;
    bus.illegal      = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: bus.ir_we = 1'b1;
        S_EXECUTE: begin
          bus.alu_src_a = (cls_q == C_AUIPC) || (cls_q == C_JAL);
          bus.alu_src_b = !((cls_q == C_RALU) || (cls_q == C_BRANCH));
          bus.imm_sel   = imm_op;
          bus.alu_ctrl  = alu_op;
          if (cls_q == C_BRANCH) begin
            bus.pc_we        = 1'b1;
            bus.branch_taken = bus.br_cond;
          end
          if (cls_q == C_JAL || cls_q == C_JALR) bus.jump = 1'b1;
        end
        S_MEM: begin
          bus.dmem_req = 1'b1;
          bus.dmem_we  = (cls_q == C_STORE);
          bus.pc_we    = bus.dmem_ready && (cls_q == C_STORE);
        end
        S_WB: begin
          bus.regWrite = 1'b1;
          bus.pc_we    = 1'b1;
          if (cls_q == C_JAL || cls_q == C_JALR) begin
            bus.jump   = 1'b1;
            bus.wb_sel = 2'd2;
          end else if (cls_q == C_LOAD) begin
            bus.wb_sel = 2'd1;
          end
        end
        S_HALT:  bus.halted  = 1'b1;
        S_TRAP:  bus.illegal = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef RV_MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;
  logic             cnt_run;

  assign cnt_run = (state_q != S_HALT) && (state_q != S_TRAP);

  // Free-running cycle and retirement counters, frozen in HALT/TRAP
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else if (cnt_run) begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (bus.pc_we) instret_cnt_q <= instret_cnt_q + CNT_W'(1);
    end
  end

  assign bus.cycle_cnt   = cycle_cnt_q;
  assign bus.instret_cnt = instret_cnt_q;
`else
  assign bus.cycle_cnt   = {CNT_W{1'b0}};
  assign bus.instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_rv_mc_controller.sv
// Self-checking bench for rv_mc_controller: directed cases followed by
// random instructions, each expanded by a per-instruction model into the
// cycle-by-cycle list of expected control outputs.
module tb_rv_mc_controller;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned CNT_W    = 32;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  localparam logic [6:0] OPS [11] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL,
                                     OP_JALR, OP_LUI, OP_AUI, OP_SYS, 7'b0000000};
  // funct3 -> ALU op for the plain (funct7[5]=0) ALU instructions
  localparam logic [3:0] F3_MAP [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   m_cyc = 0;
  int   m_ret = 0;

  rv_mc_controller_if #(.CNT_W(CNT_W)) bus ();

  rv_mc_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  wire [19:0] obs = {bus.ir_we, bus.pc_we, bus.branch_taken, bus.jump, bus.regWrite,
                     bus.alu_src_a, bus.alu_src_b, bus.imm_sel, bus.alu_ctrl, bus.wb_sel,
                     bus.dmem_req, bus.dmem_we, bus.halted, bus.illegal};

  function automatic logic [19:0] vec(input bit ir, input bit pc, input bit bt, input bit jmp,
                                      input bit rw, input bit sa, input bit sb,
                                      input logic [2:0] imm, input logic [3:0] alu,
                                      input logic [1:0] wb, input bit req, input bit we,
                                      input bit hlt, input bit ill);
    return {ir, pc, bt, jmp, rw, sa, sb, imm, alu, wb, req, we, hlt, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.dmem_ready = 1'($urandom);
    @(negedge clk);
    check("reset_outs", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_cyc = 0;
    m_ret = 0;
  endtask

  task automatic step(input logic [19:0] ev, input bit rdy, input string tag);
    bus.dmem_ready = rdy;
    @(negedge clk);
    check(tag, 32'(obs), 32'(ev));
`ifdef RV_MC_PERF_CNT_EN
    check("cycle_cnt", bus.cycle_cnt, m_cyc);
    check("instret_cnt", bus.instret_cnt, m_ret);
`else
    check("cycle_cnt", bus.cycle_cnt, 32'd0);
    check("instret_cnt", bus.instret_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    if (!ev[1] && !ev[0]) m_cyc++;
    if (ev[18]) m_ret++;
  endtask

  // wt >= MAX_WAIT means dmem_ready never arrives (timeout).
  // abort_at != 0 asserts reset in place of that cycle index.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input bit bc, input int unsigned wt, input int unsigned abort_at);
    logic [19:0] ev[$];
    bit          rd[$];
    bit is_r, is_i, is_ld, is_st, is_br, is_jmp, is_lui, is_aui, is_jal, known;
    logic [3:0]  alu;
    logic [2:0]  imm;
    logic [19:0] last;

    is_r   = (op == OP_R);
    is_i   = (op == OP_I);
    is_ld  = (op == OP_LD);
    is_st  = (op == OP_ST);
    is_br  = (op == OP_BR);
    is_jal = (op == OP_JAL);
    is_jmp = is_jal || (op == OP_JALR);
    is_lui = (op == OP_LUI);
    is_aui = (op == OP_AUI);
    known  = is_r || is_i || is_ld || is_st || is_br || is_jmp || is_lui || is_aui;

    alu = 4'd0;
    if (is_r || is_i) begin
      alu = F3_MAP[f3];
      if (f7[5] && f3 == 3'd5) alu = 4'd7;
      if (f7[5] && f3 == 3'd0 && is_r) alu = 4'd1;
    end else if (is_br) alu = 4'd1;
    else if (is_lui) alu = 4'd10;
    imm = is_st ? 3'd1 : is_br ? 3'd2 : (is_lui || is_aui) ? 3'd3 : is_jal ? 3'd4 : 3'd0;

    ev.push_back(vec(1,0,0,0,0,0,0,0,0,0,0,0,0,0)); rd.push_back(1'($urandom));
    ev.push_back('0);                               rd.push_back(1'($urandom));
    if (op == OP_SYS) begin
      repeat (3) begin ev.push_back(vec(0,0,0,0,0,0,0,0,0,0,0,0,1,0)); rd.push_back(1'($urandom)); end
    end else if (!known) begin
      repeat (3) begin ev.push_back(vec(0,0,0,0,0,0,0,0,0,0,0,0,0,1)); rd.push_back(1'($urandom)); end
    end else begin
      ev.push_back(vec(0, is_br, is_br && bc, is_jmp, 0, is_aui || is_jal, !(is_r || is_br),
                       imm, alu, 0, 0, 0, 0, 0));
      rd.push_back(1'($urandom));
      if (is_ld || is_st) begin
        if (wt >= MAX_WAIT) begin
          repeat (MAX_WAIT) begin ev.push_back(vec(0,0,0,0,0,0,0,0,0,0,1,is_st,0,0)); rd.push_back(1'b0); end
          repeat (3) begin ev.push_back(vec(0,0,0,0,0,0,0,0,0,0,0,0,0,1)); rd.push_back(1'($urandom)); end
        end else begin
          repeat (wt) begin ev.push_back(vec(0,0,0,0,0,0,0,0,0,0,1,is_st,0,0)); rd.push_back(1'b0); end
          ev.push_back(vec(0,is_st,0,0,0,0,0,0,0,0,1,is_st,0,0)); rd.push_back(1'b1);
          if (is_ld) begin ev.push_back(vec(0,1,0,0,1,0,0,0,0,1,0,0,0,0)); rd.push_back(1'($urandom)); end
        end
      end else if (!is_br) begin
        ev.push_back(vec(0,1,0,is_jmp,1,0,0,0,0,is_jmp ? 2'd2 : 2'd0,0,0,0,0));
        rd.push_back(1'($urandom));
      end
    end

    bus.opcode  = op;
    bus.funct3  = f3;
    bus.funct7  = f7;
    bus.br_cond = bc;
    foreach (ev[i]) begin
      if (abort_at != 0 && i == abort_at) begin
        do_reset();
        return;
      end
      step(ev[i], rd[i], $sformatf("op%07b f3=%0d c%0d", op, f3, i));
    end
    last = ev[ev.size()-1];
    if (last[1] || last[0]) do_reset();
  endtask

  initial begin
    logic [6:0]  op;
    int unsigned pick;

    bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
    bus.br_cond = 1'b0; bus.dmem_ready = 1'b0;
    do_reset();

    // Three ALU ops back to back: 12 cycles, 3 retirements
    run_instr(OP_R, 3'd0, 7'b0000000, 0, 0, 0);
    run_instr(OP_R, 3'd0, 7'b0100000, 0, 0, 0);
    run_instr(OP_I, 3'd5, 7'b0100000, 0, 0, 0);
`ifdef RV_MC_PERF_CNT_EN
    check("perf_cycles", bus.cycle_cnt, 32'd12);
    check("perf_instret", bus.instret_cnt, 32'd3);
`else
    check("perf_cycles", bus.cycle_cnt, 32'd0);
    check("perf_instret", bus.instret_cnt, 32'd0);
`endif
    run_instr(OP_LD, 3'd2, 7'd0, 0, 3, 0);
    run_instr(OP_BR, 3'd0, 7'd0, 1, 0, 0);
    run_instr(OP_BR, 3'd0, 7'd0, 0, 0, 0);
    run_instr(OP_ST, 3'd2, 7'd0, 0, 0, 0);
    run_instr(OP_JAL, 3'd0, 7'd0, 0, 0, 0);
    run_instr(7'b0000000, 3'd0, 7'd0, 0, 0, 0);
    run_instr(OP_LD, 3'd2, 7'd0, 0, MAX_WAIT, 0);
    run_instr(OP_SYS, 3'd0, 7'd0, 0, 0, 0);
    // Reset during the second MEM wait cycle, then a normal instruction
    run_instr(OP_LD, 3'd2, 7'd0, 0, MAX_WAIT, 4);
    run_instr(OP_LUI, 3'd0, 7'd0, 0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      pick = $urandom_range(0, 11);
      op = (pick == 11) ? 7'($urandom) : OPS[pick];
      run_instr(op, 3'($urandom), 7'($urandom), 1'($urandom),
                $urandom_range(0, MAX_WAIT), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
